// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift sequencer and its users.
package shift_seq_pkg;

    localparam int SEQ_W  = 8;
    localparam int SEQ_SW = 3;
    localparam int SEQ_CW = 4;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_ROT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Iterative control stage around an external combinational barrel shifter.
// Optional feature macro: SHIFT_SEQUENCER_ABORT_EN adds an abort input honoured in RUN.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int W  = SEQ_W,
    parameter int SW = SEQ_SW,
    parameter int CW = SEQ_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef SHIFT_SEQUENCER_ABORT_EN
    input  logic          abort,
`endif
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] amt,
    input  logic          mode,
    input  logic [CW-1:0] steps,
    output logic [W-1:0]  shf_in,
    output logic [SW-1:0] shf_sel,
    output logic          shf_mode,
    input  logic [W-1:0]  shf_out,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  dout
);

    seq_state_t    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [SW-1:0] amt_q, amt_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          abort_w;

`ifdef SHIFT_SEQUENCER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = din;
                    amt_d   = amt;
                    mode_d  = mode;
                    cnt_d   = steps;
                    state_d = (steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // An aborted pass discards the shifter result so acc keeps its last value.
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    acc_d = shf_out;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                dout_d  = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign shf_in   = acc_q;
    assign shf_sel  = amt_q;
    assign shf_mode = mode_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    // Bypass so the result is visible in the same cycle as the done pulse.
    assign dout     = done ? acc_q : dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer with a behavioural shifter beside it.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] amt = 3'd0;
    logic       mode = 1'b0;
    logic [3:0] steps = 4'd0;
    logic [7:0] shf_in;
    logic [2:0] shf_sel;
    logic       shf_mode;
    logic [7:0] shf_out;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] shift_once(logic [7:0] x, logic [2:0] a, logic m);
        logic [15:0] t;
        t = {x, x} << a;
        return m ? t[15:8] : (x << a);
    endfunction

    function automatic logic [7:0] shift_n(logic [7:0] x, logic [2:0] a, logic m, int n);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = shift_once(v, a, m);
        return v;
    endfunction

    assign shf_out = shift_once(shf_in, shf_sel, shf_mode);

    shift_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SHIFT_SEQUENCER_ABORT_EN
        .abort    (abort),
`endif
        .din      (din),
        .amt      (amt),
        .mode     (mode),
        .steps    (steps),
        .shf_in   (shf_in),
        .shf_sel  (shf_sel),
        .shf_mode (shf_mode),
        .shf_out  (shf_out),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a command occupies steps+1 busy cycles; the shifter input is the
    // command byte after however many passes have completed so far.
    int         m_rem  = 0;
    int         m_pass = 0;
    logic [7:0] m_din  = 8'h00;
    logic [2:0] m_amt  = 3'd0;
    logic       m_mode = 1'b0;
    int         m_steps = 0;
    logic [7:0] m_dout = 8'h00;
    logic       abort_v;

`ifdef SHIFT_SEQUENCER_ABORT_EN
    assign abort_v = abort;
`else
    assign abort_v = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_rem   <= 0;
            m_pass  <= 0;
            m_din   <= 8'h00;
            m_amt   <= 3'd0;
            m_mode  <= 1'b0;
            m_steps <= 0;
            m_dout  <= 8'h00;
        end else if (m_rem == 0) begin
            if (start) begin
                m_din   <= din;
                m_amt   <= amt;
                m_mode  <= mode;
                m_steps <= int'(steps);
                m_pass  <= 0;
                m_rem   <= int'(steps) + 1;
            end
        end else if (m_rem > 1 && abort_v) begin
            m_rem <= 0;
        end else begin
            if (m_rem > 1) m_pass <= m_pass + 1;
            if (m_rem == 1) m_dout <= shift_n(m_din, m_amt, m_mode, m_steps);
            m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] exp_dout;
            exp_dout = (m_rem == 1) ? shift_n(m_din, m_amt, m_mode, m_steps) : m_dout;
            chk("busy", int'(busy), int'(m_rem > 0));
            chk("done", int'(done), int'(m_rem == 1));
            chk("dout", int'(dout), int'(exp_dout));
            chk("shf_in", int'(shf_in), int'(shift_n(m_din, m_amt, m_mode, m_pass)));
            chk("shf_sel", int'(shf_sel), int'(m_amt));
            chk("shf_mode", int'(shf_mode), int'(m_mode));
            if (m_rem == 1)
                $display("txn din=%02h amt=%0d mode=%0d steps=%0d -> dout=%02h (model %02h)",
                         m_din, m_amt, m_mode, m_steps, dout, exp_dout);
        end
    end

    task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input logic m,
                           input logic [3:0] s, input logic [7:0] exp_dout, input int exp_lat,
                           input int mid_n, input logic [7:0] mid_val, input int restart_at);
        int n;
        @(posedge clk); #1;
        start = 1'b1; din = d; amt = a; mode = m; steps = s;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == mid_n) chk("mid_shf_in", int'(shf_in), int'(mid_val));
            start = (n + 1 == restart_at);
            if (start) begin din = 8'hFF; steps = 4'd1; end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, exp_lat);
        chk("done_dout", int'(dout), int'(exp_dout));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_dout", int'(dout), 0);
        end

        // Two 4-bit rotates bring C3 back to itself; first pass yields 3C.
        run_cmd(8'hC3, 3'd4, 1'b1, 4'd2, 8'hC3, 2, 1, 8'h3C, -1);
        // Zero steps: result is din directly, one busy cycle.
        run_cmd(8'hA5, 3'd3, 1'b0, 4'd0, 8'hA5, 0, -1, 8'h00, -1);
        @(posedge clk); #1;
        chk("zero_step_busy_off", int'(busy), 0);
        // Fifteen logical left shifts clear the byte; a start mid-run is ignored.
        run_cmd(8'hC3, 3'd1, 1'b0, 4'd15, 8'h00, 15, 1, 8'h86, 5);

        // Reset in the middle of a long command.
        @(posedge clk); #1;
        start = 1'b1; din = 8'h5A; amt = 3'd2; mode = 1'b1; steps = 4'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dout", int'(dout), 0);
        run_cmd(8'h81, 3'd1, 1'b1, 4'd3, 8'h0C, 3, -1, 8'h00, -1);

`ifdef SHIFT_SEQUENCER_ABORT_EN
        @(posedge clk); #1;
        start = 1'b1; din = 8'h33; amt = 3'd1; mode = 1'b0; steps = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_dout", int'(dout), 8'h0C);
`endif

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 15) == 0);
            din   = 8'($urandom);
            amt   = 3'($urandom);
            mode  = 1'($urandom);
            steps = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
